// File: rtl/core_mem_access_if.sv
// ---------------------------------------------------------------------------
// core_mem_access_if
// Request/acknowledge port between the memory-stage access unit and the local
// data cache.
//   dc_req     : request, held high until dc_ack
//   dc_we      : 1 = write, 0 = read
//   dc_addr    : word-aligned byte address
//   dc_wdata   : lane-replicated store data
//   dc_byte_en : byte-lane enables, little-endian
//   dc_ack     : one-cycle completion pulse from the cache
//   dc_rdata   : read word, valid together with dc_ack
// Modports: master = access unit, slave = data cache.
// ---------------------------------------------------------------------------
interface core_mem_access_if #(
  parameter int ADDR_W = 32
) ();
  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [31:0]       dc_wdata;
  logic [3:0]        dc_byte_en;
  logic              dc_ack;
  logic [31:0]       dc_rdata;

  modport master (
    output dc_req, dc_we, dc_addr, dc_wdata, dc_byte_en,
    input  dc_ack, dc_rdata
  );

  modport slave (
    input  dc_req, dc_we, dc_addr, dc_wdata, dc_byte_en,
    output dc_ack, dc_rdata
  );
endinterface

// File: rtl/core_mem_access.sv
// ---------------------------------------------------------------------------
// core_mem_access
// Memory-stage access unit. Converts load/store control from the ex/mem
// register into a req/ack transaction on the data-cache port, formats load
// data, and signals mem/wb when the stage is complete.
// Ports:
//   clk, rst         : clock (rising edge), asynchronous active-low reset
//   mem_read/write   : load / store in mem stage (both set = load)
//   mem_size         : 00 byte, 01 half, 10/11 word
//   mem_unsigned     : 1 = zero-extend loads, 0 = sign-extend
//   mem_addr         : byte address
//   mem_wdata        : store data
//   dc               : data-cache port (core_mem_access_if.master)
//   read_memdata     : formatted load result
//   v_read_memdata   : stage complete, mem/wb may capture
//   mem_stall        : freezes upstream stages (~v_read_memdata out of reset)
//   mem_misalign     : misaligned-access flag
// Optional feature macro: MEM_MISALIGN_CHECK_EN -- when defined, misaligned
// half/word accesses skip the cache and complete with mem_misalign=1.
// ---------------------------------------------------------------------------
module core_mem_access #(
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [1:0]          mem_size,
  input  logic                mem_unsigned,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [31:0]         mem_wdata,
  core_mem_access_if.master   dc,
  output logic [31:0]         read_memdata,
  output logic                v_read_memdata,
  output logic                mem_stall,
  output logic                mem_misalign
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_reg;
  logic              dc_req_reg;
  logic              dc_we_reg;
  logic [ADDR_W-1:0] dc_addr_reg;
  logic [31:0]       dc_wdata_reg;
  logic [3:0]        dc_byte_en_reg;
  logic [31:0]       read_memdata_reg;
  // Access attributes captured at issue so formatting does not depend on the
  // upstream register still holding the same instruction at ack time.
  logic [1:0]        off_reg;
  logic [1:0]        size_reg;
  logic              uns_reg;

  logic        op;
  logic [3:0]  byte_en_next;
  logic [31:0] wdata_next;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_fmt;

  assign op = mem_read | mem_write;

  always_comb begin
    byte_en_next = 4'b1111;
    wdata_next   = mem_wdata;
    case (mem_size)
      2'b00: begin
        byte_en_next = 4'b0001 << mem_addr[1:0];
        wdata_next   = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        byte_en_next = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next   = {2{mem_wdata[15:0]}};
      end
      default: begin
        byte_en_next = 4'b1111;
        wdata_next   = mem_wdata;
      end
    endcase
  end

  // Load formatting from the captured lane offset / size / signedness.
  always_comb begin
    load_byte = dc.dc_rdata[7:0];
    case (off_reg)
      2'd0:    load_byte = dc.dc_rdata[7:0];
      2'd1:    load_byte = dc.dc_rdata[15:8];
      2'd2:    load_byte = dc.dc_rdata[23:16];
      default: load_byte = dc.dc_rdata[31:24];
    endcase
    load_half = off_reg[1] ? dc.dc_rdata[31:16] : dc.dc_rdata[15:0];
    case (size_reg)
      2'b00:   load_fmt = {{24{~uns_reg & load_byte[7]}}, load_byte};
      2'b01:   load_fmt = {{16{~uns_reg & load_half[15]}}, load_half};
      default: load_fmt = dc.dc_rdata;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic misalign_now;
  logic mem_misalign_reg;

  always_comb begin
    case (mem_size)
      2'b00:   misalign_now = 1'b0;
      2'b01:   misalign_now = mem_addr[0];
      default: misalign_now = |mem_addr[1:0];
    endcase
  end

  assign mem_misalign = mem_misalign_reg;
`else
  assign mem_misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      dc_req_reg       <= 1'b0;
      dc_we_reg        <= 1'b0;
      dc_addr_reg      <= '0;
      dc_wdata_reg     <= '0;
      dc_byte_en_reg   <= '0;
      read_memdata_reg <= '0;
      off_reg          <= '0;
      size_reg         <= '0;
      uns_reg          <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      mem_misalign_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (op) begin
`ifdef MEM_MISALIGN_CHECK_EN
            if (misalign_now) begin
              // Complete without touching the cache.
              mem_misalign_reg <= 1'b1;
              read_memdata_reg <= '0;
              state_reg        <= DONE;
            end else
`endif
            begin
              dc_req_reg     <= 1'b1;
              dc_we_reg      <= ~mem_read & mem_write;
              dc_addr_reg    <= {mem_addr[ADDR_W-1:2], 2'b00};
              dc_wdata_reg   <= wdata_next;
              dc_byte_en_reg <= byte_en_next;
              off_reg        <= mem_addr[1:0];
              size_reg       <= mem_size;
              uns_reg        <= mem_unsigned;
              state_reg      <= BUSY;
            end
          end
        end
        BUSY: begin
          if (dc.dc_ack) begin
            dc_req_reg <= 1'b0;
            if (!dc_we_reg) read_memdata_reg <= load_fmt;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          // The upstream op is still visible here; it belongs to the
          // instruction just completed, so no new request is issued.
`ifdef MEM_MISALIGN_CHECK_EN
          mem_misalign_reg <= 1'b0;
`endif
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    v_read_memdata = 1'b0;
    if (rst) begin
      if (state_reg == DONE)                 v_read_memdata = 1'b1;
      else if (state_reg == IDLE && !op)     v_read_memdata = 1'b1;
    end
  end

  assign mem_stall     = rst & ~v_read_memdata;
  assign read_memdata  = read_memdata_reg;
  assign dc.dc_req     = dc_req_reg;
  assign dc.dc_we      = dc_we_reg;
  assign dc.dc_addr    = dc_addr_reg;
  assign dc.dc_wdata   = dc_wdata_reg;
  assign dc.dc_byte_en = dc_byte_en_reg;

endmodule

// File: doc/core_mem_access.md
Name: core_mem_access

Overview:
- Memory-stage access unit between the ex/mem pipeline register and the mem/wb pipeline register.
- Turns load/store control from ex/mem into a req/ack transaction on the local data-cache port.
- Formats load data (byte/half/word, sign/zero extend) into read_memdata.
- Drives v_read_memdata, the advance-enable of mem/wb; mem_stall freezes the upstream stages.

Parameters:
ADDR_W, 32, byte-address width of mem_addr and dc_addr

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
mem_read  input  1  load in mem stage
mem_write  input  1  store in mem stage
mem_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
mem_unsigned  input  1  1 = zero-extend loads, 0 = sign-extend
mem_addr  input  ADDR_W  byte address (aluresult)
mem_wdata  input  32  store data (low bits used for byte/half)
dc_req  output  1  cache request, held until dc_ack
dc_we  output  1  1 = write
dc_addr  output  ADDR_W  word-aligned address {mem_addr[ADDR_W-1:2],2'b00}
dc_wdata  output  32  lane-replicated store data
dc_byte_en  output  4  byte-lane enables, little-endian
dc_ack  input  1  one-cycle completion pulse
dc_rdata  input  32  read word, valid with dc_ack
read_memdata  output  32  formatted load result to mem/wb
v_read_memdata  output  1  mem stage complete; mem/wb may capture
mem_stall  output  1  equals ~v_read_memdata while out of reset
mem_misalign  output  1  misaligned-access flag (see Optional Feature)

Behaviour:
- Reset (rst=0, async): state IDLE; dc_req, dc_we, dc_wdata, dc_byte_en, dc_addr, read_memdata, mem_misalign all 0.
- While rst=0: v_read_memdata=0 and mem_stall=0, combinationally.
- op = mem_read | mem_write. If both are 1, the access is a load (dc_we=0).
- FSM states: IDLE, BUSY, DONE.
- IDLE, op=0: v_read_memdata=1; stay IDLE; no request.
- IDLE, op=1: v_read_memdata=0. Next edge: register dc_req=1, dc_we, dc_addr, dc_wdata, dc_byte_en; go to BUSY.
- BUSY: dc_req and all dc_* outputs held stable until dc_ack=1.
- BUSY, on the dc_ack edge: dc_req<=0; if load, read_memdata<=formatted dc_rdata; go to DONE.
- BUSY, store ack: read_memdata keeps its prior value.
- DONE: v_read_memdata=1 for exactly one cycle, then go to IDLE unconditionally. No request is issued in DONE, even though inputs still show the same op.
- Minimum load/store latency: op seen in IDLE at cycle 0, dc_ack in cycle 1, v_read_memdata=1 in cycle 2.
- dc_ack while IDLE or DONE (stray or late) is ignored.
- Byte enables: byte -> 0001<<addr[1:0]; half -> 0011<<(addr[1]*2); word -> 1111.
- Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word as-is.
- Load formatting: lane = dc_rdata >> (8*addr[1:0]). Byte = lane[7:0] extended; half = lane[15:0] extended (half uses addr[1] only, addr[0] ignored when the check is off). Extension per mem_unsigned.
- Reset mid-BUSY: dc_req drops immediately; FSM returns to IDLE; a subsequent dc_ack is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- Defined: a misaligned access is half with addr[0]=1, or word with addr[1:0]!=0.
  - In IDLE it issues no dc_req and goes straight to DONE on the next edge.
  - In DONE: mem_misalign=1 and v_read_memdata=1 for one cycle; read_memdata<=0.
- Not defined: mem_misalign is constant 0; low address bits are truncated per the lane rules and the access proceeds normally.

Test Plan:
- Idle pass-through: mem_read=mem_write=0 for 5 cycles -> v_read_memdata=1, dc_req=0 throughout, mem_stall=0.
- Signed byte load: addr=0x1003, size=00, unsigned=0, dc_rdata=0x80_11_22_33, ack 3 cycles after req.
  - Expect dc_addr=0x1000, byte_en=1000.
  - Expect v_read_memdata=0 until DONE, then read_memdata=0xFFFFFF80, v=1 for one cycle.
- Unsigned half load: addr=0x2002, size=01, unsigned=1, dc_rdata=0xBEEF_1234 -> byte_en=1100, read_memdata=0x0000BEEF.
- Byte store: addr=0x3001, size=00, wdata=0x000000A5 -> dc_we=1, byte_en=0010, dc_wdata=0xA5A5A5A5; read_memdata unchanged after DONE.
- Async reset mid-BUSY: drop rst while dc_req=1, then release and pulse dc_ack -> dc_req=0 at once; FSM stays IDLE; read_memdata=0.
- With MEM_MISALIGN_CHECK_EN: word load at addr=0x4002 -> no dc_req; next cycle mem_misalign=1, v_read_memdata=1, read_memdata=0.
